icache_refill_bridge: RTL and testbench

//  Downstream neighbour of the instruction cache. Accepts a 1-cycle line-fill request (line-aligned address),

---
 rtl/icache_pkg.sv | 16 +
 rtl/icache_refill_line_buf.sv | 50 +++++
 rtl/icache_refill_bridge.sv | 193 +++++++++++++++++++
 tb/tb_icache_refill_bridge.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared refill constants and FSM state encodings.
// No ports; imported by the refill bridge and its line buffer.
package icache_pkg;

  localparam int LINE_BYTES = 16;
  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = 4;
  localparam int WORD_IDX_W = 2;

  typedef enum logic [1:0] {
    RF_IDLE  = 2'd0,
    RF_FILL  = 2'd1,
    RF_DRAIN = 2'd2
  } refill_state_e;

endpackage

// File: rtl/icache_refill_line_buf.sv
// icache_refill_line_buf: one-entry line store with tag compare.
// Ports: clk, rst_n, load_i/load_tag_i/load_data_i, lookup_tag_i, hit_o, data_o.
module icache_refill_line_buf
  import icache_pkg::*;
#(
  parameter int TAG_W  = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [TAG_W-1:0]  load_tag_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic              buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]  buf_tag_q, buf_tag_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    if (load_i) begin
      buf_valid_d = 1'b1;
      buf_tag_d   = load_tag_i;
      buf_data_d  = load_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign hit_o  = buf_valid_q &&
                  (buf_tag_q == lookup_tag_i);
  assign data_o = buf_data_q;

endmodule

// File: rtl/icache_refill_bridge.sv
// icache_refill_bridge: fetches a 16-byte line as 4 word reads, returns it.
// Ports: icache req/ready/data, bus req/addr/ack/rdata. Opt: ICACHE_REFILL_LINE_BUF_EN.
module icache_refill_bridge
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        icache_addr_i,
  input  logic                     icache_valid_req_i,
  output logic                     mem_ready_o,
  output logic [32*LINE_WORDS-1:0] mem_data_o,
  output logic                     bus_req_o,
  output logic [ADDR_W-1:0]        bus_addr_o,
  input  logic                     bus_ack_i,
  input  logic [31:0]              bus_rdata_i
);

  localparam int TAG_W  = ADDR_W - OFFSET_W;
  localparam int DATA_W = 32 * LINE_WORDS;

  refill_state_e state_q, state_d;

  logic [TAG_W-1:0]      line_q, line_d;
  logic [TAG_W-1:0]      pend_line_q, pend_line_d;
  logic [WORD_IDX_W-1:0] beat_q, beat_d;
  logic                  pend_q, pend_d;
  logic                  ready_q, ready_d;
  logic [DATA_W-1:0]     asm_q, asm_d;
  logic [DATA_W-1:0]     data_q, data_d;

  logic [TAG_W-1:0]  req_line;
  logic [DATA_W-1:0] asm_next;
  logic              last_beat;
  logic              fill_done;
  logic              bypass;
  logic [DATA_W-1:0] buf_data;
  logic              unused_offset;

  assign req_line  = icache_addr_i[ADDR_W-1:OFFSET_W];
  assign last_beat =
    (beat_q == WORD_IDX_W'(LINE_WORDS - 1));
  assign unused_offset = ^icache_addr_i[OFFSET_W-1:0];

  // Current line image with the acked beat merged in.
  always_comb begin
    asm_next = asm_q;
    asm_next[beat_q*32 +: 32] = bus_rdata_i;
  end

  // Final beat accepted without a competing redirect.
  assign fill_done = (state_q == RF_FILL) &&
                     bus_ack_i &&
                     !icache_valid_req_i &&
                     last_beat;

`ifdef ICACHE_REFILL_LINE_BUF_EN
  logic buf_hit;

  icache_refill_line_buf #(
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_line_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (fill_done),
    .load_tag_i   (line_q),
    .load_data_i  (asm_next),
    .lookup_tag_i (req_line),
    .hit_o        (buf_hit),
    .data_o       (buf_data)
  );

  // A hit in the ready cycle would give two
  // back-to-back ready pulses; send it to the bus.
  assign bypass = (state_q == RF_IDLE) &&
                  icache_valid_req_i &&
                  buf_hit && !ready_q;
`else
  assign bypass   = 1'b0;
  assign buf_data = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RF_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RF_IDLE: begin
        if (icache_valid_req_i && !bypass)
          state_d = RF_FILL;
      end
      RF_FILL: begin
        if (icache_valid_req_i && !bus_ack_i)
          state_d = RF_DRAIN;
        else if (fill_done)
          state_d = RF_IDLE;
      end
      RF_DRAIN: begin
        if (bus_ack_i) state_d = RF_FILL;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_comb begin
    bus_req_o  = (state_q != RF_IDLE);
    bus_addr_o = {line_q, beat_q, 2'b00};
  end

  always_comb begin
    line_d      = line_q;
    pend_line_d = pend_line_q;
    beat_d      = beat_q;
    pend_d      = pend_q;
    ready_d     = 1'b0;
    asm_d       = asm_q;
    data_d      = data_q;
    unique case (state_q)
      RF_IDLE: begin
        if (icache_valid_req_i) begin
          if (bypass) begin
            ready_d = 1'b1;
            data_d  = buf_data;
          end else begin
            line_d = req_line;
            beat_d = '0;
          end
        end
      end
      RF_FILL: begin
        if (icache_valid_req_i) begin
          if (bus_ack_i) begin
            line_d = req_line;
            beat_d = '0;
          end else begin
            pend_line_d = req_line;
            pend_d      = 1'b1;
          end
        end else if (bus_ack_i) begin
          asm_d = asm_next;
          if (last_beat) begin
            ready_d = 1'b1;
            data_d  = asm_next;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      RF_DRAIN: begin
        if (icache_valid_req_i)
          pend_line_d = req_line;
        if (bus_ack_i) begin
          line_d = icache_valid_req_i ?
                   req_line : pend_line_q;
          beat_d = '0;
          pend_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q      <= '0;
      pend_line_q <= '0;
      beat_q      <= '0;
      pend_q      <= 1'b0;
      ready_q     <= 1'b0;
      asm_q       <= '0;
      data_q      <= '0;
    end else begin
      line_q      <= line_d;
      pend_line_q <= pend_line_d;
      beat_q      <= beat_d;
      pend_q      <= pend_d;
      ready_q     <= ready_d;
      asm_q       <= asm_d;
      data_q      <= data_d;
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_data_o  = data_q;

endmodule

// File: tb/tb_icache_refill_bridge.sv
// tb_icache_refill_bridge: directed latency cases plus random
// traffic checked against a transaction-level line model.
module tb_icache_refill_bridge;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  icache_addr_i = '0;
  logic         icache_valid_req_i = 1'b0;
  logic         mem_ready_o;
  logic [127:0] mem_data_o;
  logic         bus_req_o;
  logic [31:0]  bus_addr_o;
  logic         bus_ack_i;
  logic [31:0]  bus_rdata_i;
  logic         ack_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  icache_refill_bridge dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .icache_addr_i      (icache_addr_i),
    .icache_valid_req_i (icache_valid_req_i),
    .mem_ready_o        (mem_ready_o),
    .mem_data_o         (mem_data_o),
    .bus_req_o          (bus_req_o),
    .bus_addr_o         (bus_addr_o),
    .bus_ack_i          (bus_ack_i),
    .bus_rdata_i        (bus_rdata_i)
  );

  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    logic [31:0] l;
    l = {4'h0, a[31:4]} - 32'h104;
    return ({30'd0, a[3:2]} + 32'd1) * 32'h11
           + (l << 8);
  endfunction

  function automatic logic [127:0] line_of(
    input logic [31:0] base);
    logic [127:0] r;
    for (int k = 0; k < 4; k++)
      r[32*k +: 32] = mem_word(base + 32'(4*k));
    return r;
  endfunction

  assign bus_ack_i   = bus_req_o & ack_en;
  assign bus_rdata_i = mem_word(bus_addr_o);

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    icache_valid_req_i = 1'b0;
    icache_addr_i = '0;
    ack_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req",  bus_req_o, 0);
    chk("rst.addr", bus_addr_o, 0);
    chk("rst.rdy",  mem_ready_o, 0);
    chk("rst.data", mem_data_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cyc(input string tag,
                     input logic rq,
                     input logic [31:0] ad,
                     input logic ak,
                     input logic e_req,
                     input logic [31:0] e_addr,
                     input logic e_rdy,
                     input logic [127:0] e_data);
    icache_valid_req_i = rq;
    icache_addr_i = ad;
    ack_en = ak;
    @(negedge clk);
    chk({tag, ".req"}, bus_req_o, e_req);
    if (e_req)
      chk({tag, ".addr"}, bus_addr_o, e_addr);
    chk({tag, ".rdy"}, mem_ready_o, e_rdy);
    if (e_rdy)
      chk({tag, ".data"}, mem_data_o, e_data);
    @(posedge clk); #1;
  endtask

  // Random-phase reference model state.
  logic        rnd_on = 1'b0;
  logic        outstanding = 1'b0;
  logic [27:0] exp_line = '0;
  logic        prev_rdy = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_addr = '0;
  logic        bufv_m = 1'b0;
  logic [27:0] buf_line_m = '0;
  logic [31:0] acks[$];
  logic        skip_beats;

  always @(negedge clk) begin
    if (rnd_on) begin
      if (mem_ready_o) begin
        chk("r.outstanding", outstanding, 1);
        chk("r.back2back", prev_rdy, 0);
        chk("r.data", mem_data_o,
            line_of({exp_line, 4'h0}));
        skip_beats = 1'b0;
`ifdef ICACHE_REFILL_LINE_BUF_EN
        skip_beats = bufv_m &&
                     (buf_line_m == exp_line);
`endif
        if (!skip_beats) begin
          chk("r.nacks", acks.size() >= 4, 1);
          if (acks.size() >= 4)
            for (int k = 0; k < 4; k++)
              chk("r.beat", acks[acks.size()-4+k],
                  {exp_line, 4'h0} + 32'(4*k));
        end
        outstanding = 1'b0;
        bufv_m = 1'b1;
        buf_line_m = exp_line;
      end
      if (stall_prev) begin
        chk("r.hold_req", bus_req_o, 1);
        chk("r.hold_addr", bus_addr_o, stall_addr);
      end
      if (bus_ack_i) begin
        acks.push_back(bus_addr_o);
        if (acks.size() > 4) void'(acks.pop_front());
      end
      stall_prev = bus_req_o && !bus_ack_i;
      stall_addr = bus_addr_o;
      if (icache_valid_req_i) begin
        outstanding = 1'b1;
        exp_line = icache_addr_i[31:4];
      end
      prev_rdy = mem_ready_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [127:0] l1;
    logic [127:0] l2;
    logic [127:0] l3;
    logic [127:0] l4;
    logic [127:0] t1_const;
    l1 = line_of(32'h1040);
    l2 = line_of(32'h2080);
    l3 = line_of(32'h3000);
    l4 = line_of(32'h0040);
    t1_const = 128'h00000044_00000033_00000022_00000011;

    // 1: zero-wait fill
    do_reset();
    cyc("t1c0", 1, 32'h1040, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++)
      cyc("t1", 0, 0, 1, 1,
          32'h1040 + 32'(4*(c-1)), 0, 0);
    cyc("t1c5", 0, 0, 1, 0, 0, 1, l1);
    chk("t1.const", mem_data_o, t1_const);
    cyc("t1c6", 0, 0, 1, 0, 0, 0, 0);
    chk("t1.hold", mem_data_o, l1);

    // 2: two wait states on beat 1
    do_reset();
    cyc("t2c0", 1, 32'h1040, 1, 0, 0, 0, 0);
    cyc("t2c1", 0, 0, 1, 1, 32'h1040, 0, 0);
    cyc("t2c2", 0, 0, 0, 1, 32'h1044, 0, 0);
    cyc("t2c3", 0, 0, 0, 1, 32'h1044, 0, 0);
    cyc("t2c4", 0, 0, 1, 1, 32'h1044, 0, 0);
    cyc("t2c5", 0, 0, 1, 1, 32'h1048, 0, 0);
    cyc("t2c6", 0, 0, 1, 1, 32'h104C, 0, 0);
    cyc("t2c7", 0, 0, 1, 0, 0, 1, l1);

    // 3: redirect without ack -> drain
    do_reset();
    cyc("t3c0", 1, 32'h1040, 1, 0, 0, 0, 0);
    cyc("t3c1", 0, 0, 1, 1, 32'h1040, 0, 0);
    cyc("t3c2", 0, 0, 1, 1, 32'h1044, 0, 0);
    cyc("t3c3", 1, 32'h2080, 0, 1, 32'h1048, 0, 0);
    cyc("t3c4", 0, 0, 1, 1, 32'h1048, 0, 0);
    for (int c = 5; c <= 8; c++)
      cyc("t3", 0, 0, 1, 1,
          32'h2080 + 32'(4*(c-5)), 0, 0);
    cyc("t3c9", 0, 0, 1, 0, 0, 1, l2);
    cyc("t3c10", 0, 0, 1, 0, 0, 0, 0);

    // 4: redirect on final ack
    do_reset();
    cyc("t4c0", 1, 32'h1040, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 3; c++)
      cyc("t4", 0, 0, 1, 1,
          32'h1040 + 32'(4*(c-1)), 0, 0);
    cyc("t4c4", 1, 32'h3000, 1, 1, 32'h104C, 0, 0);
    for (int c = 5; c <= 8; c++)
      cyc("t4", 0, 0, 1, 1,
          32'h3000 + 32'(4*(c-5)), 0, 0);
    cyc("t4c9", 0, 0, 1, 0, 0, 1, l3);
    cyc("t4c10", 0, 0, 1, 0, 0, 0, 0);

    // 5: async reset mid-fill
    cyc("t5c0", 1, 32'h1040, 1, 0, 0, 0, 0);
    cyc("t5c1", 0, 0, 1, 1, 32'h1040, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("t5.rst_req",  bus_req_o, 0);
    chk("t5.rst_addr", bus_addr_o, 0);
    chk("t5.rst_rdy",  mem_ready_o, 0);
    chk("t5.rst_data", mem_data_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("t5r0", 1, 32'h0040, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++)
      cyc("t5r", 0, 0, 1, 1,
          32'h0040 + 32'(4*(c-1)), 0, 0);
    cyc("t5r5", 0, 0, 1, 0, 0, 1, l4);

`ifdef ICACHE_REFILL_LINE_BUF_EN
    // 6: buffer hit bypasses the bus
    do_reset();
    cyc("t6c0", 1, 32'h1040, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++)
      cyc("t6", 0, 0, 1, 1,
          32'h1040 + 32'(4*(c-1)), 0, 0);
    cyc("t6c5", 0, 0, 1, 0, 0, 1, l1);
    cyc("t6c6", 1, 32'h104C, 1, 0, 0, 0, 0);
    cyc("t6c7", 0, 0, 1, 0, 0, 1, l1);
    cyc("t6c8", 1, 32'h1050, 1, 0, 0, 0, 0);
    cyc("t6c9", 0, 0, 1, 1, 32'h1050, 0, 0);
    repeat (6) cyc("t6t", 0, 0, 1, bus_req_o,
                   bus_addr_o, mem_ready_o, mem_data_o);
`endif

    // Random traffic against the line model.
    do_reset();
    rnd_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      icache_valid_req_i = ($urandom_range(0, 5) == 0);
      icache_addr_i = 32'h1000
        + (32'($urandom_range(0, 7)) << 4)
        + 32'($urandom_range(0, 15));
      ack_en = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    icache_valid_req_i = 1'b0;
    ack_en = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("r.drained", outstanding, 0);
    rnd_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
